// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: multi-cycle data-memory access with upstream stall,
// misalignment squash and registered hand-off to write-back.
module mem_wb_stage #(
  parameter int DEPTH      = 256,
  parameter int ACCESS_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_in,
  input  logic [1:0]  mem_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] rt_in,
  input  logic [4:0]  reg_dest_in,
  output logic [1:0]  wb_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_res_out,
  output logic [4:0]  reg_dest_out,
  output logic        stall,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;

  logic [31:0]     mem [DEPTH];

  logic [1:0]      cap_wb;
  logic [1:0]      cap_mem;
  logic [31:0]     cap_alu;
  logic [31:0]     cap_rt;
  logic [4:0]      cap_dest;

  logic            mem_req, aligned, mem_op, misaligned;
  logic [AW-1:0]   word;
  logic            mem_we;

  logic [1:0]      nxt_wb;
  logic [31:0]     nxt_rd;
  logic [31:0]     nxt_alu;
  logic [4:0]      nxt_dest;
  logic            nxt_err;

  assign mem_req    = |mem_in;
  assign aligned    = (alu_res_in[1:0] == 2'b00);
  assign mem_op     = mem_req & aligned;
  assign misaligned = mem_req & ~aligned;
  assign word       = cap_alu[AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_op) begin
          state_nxt = BUSY;
          cnt_nxt   = CW'(ACCESS_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else           state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Everything here is gated by rst so a reset mid-access commits nothing.
  always_comb begin
    stall    = 1'b0;
    mem_we   = 1'b0;
    nxt_wb   = '0;
    nxt_rd   = '0;
    nxt_alu  = '0;
    nxt_dest = '0;
    nxt_err  = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            stall = 1'b1;
          end else if (misaligned) begin
            nxt_alu  = alu_res_in;
            nxt_dest = reg_dest_in;
            nxt_err  = 1'b1;
          end else begin
            nxt_wb   = wb_in;
            nxt_alu  = alu_res_in;
            nxt_dest = reg_dest_in;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            stall = 1'b1;
          end else begin
            mem_we   = cap_mem[0];
            nxt_wb   = cap_wb;
            nxt_rd   = (cap_mem == 2'b10) ? mem[word] : '0;
            nxt_alu  = cap_alu;
            nxt_dest = cap_dest;
          end
        end
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_out        <= '0;
      read_data_out <= '0;
      alu_res_out   <= '0;
      reg_dest_out  <= '0;
      misalign_err  <= 1'b0;
    end else begin
      wb_out        <= nxt_wb;
      read_data_out <= nxt_rd;
      alu_res_out   <= nxt_alu;
      reg_dest_out  <= nxt_dest;
      misalign_err  <= nxt_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && state == IDLE && mem_op) begin
      cap_wb   <= wb_in;
      cap_mem  <= mem_in;
      cap_alu  <= alu_res_in;
      cap_rt   <= rt_in;
      cap_dest <= reg_dest_in;
    end
  end

  // Data memory is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word] <= cap_rt;
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a behavioural model predicts each edge's
// outputs, pushes them to a queue, and the post-edge sample pops and compares.
module tb_mem_wb_stage;

  localparam int DEPTH      = 256;
  localparam int ACCESS_LAT = 2;
  localparam int AW         = $clog2(DEPTH);

  logic        clk;
  logic        rst;
  logic [1:0]  wb_in;
  logic [1:0]  mem_in;
  logic [31:0] alu_res_in;
  logic [31:0] rt_in;
  logic [4:0]  reg_dest_in;
  logic [1:0]  wb_out;
  logic [31:0] read_data_out;
  logic [31:0] alu_res_out;
  logic [4:0]  reg_dest_out;
  logic        stall;
  logic        misalign_err;

  mem_wb_stage #(.DEPTH(DEPTH), .ACCESS_LAT(ACCESS_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_in        (wb_in),
    .mem_in       (mem_in),
    .alu_res_in   (alu_res_in),
    .rt_in        (rt_in),
    .reg_dest_in  (reg_dest_in),
    .wb_out       (wb_out),
    .read_data_out(read_data_out),
    .alu_res_out  (alu_res_out),
    .reg_dest_out (reg_dest_out),
    .stall        (stall),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] m_mem [DEPTH];
  logic        m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [1:0]  c_wb, c_mem;
  logic [31:0] c_alu, c_rt;
  logic [4:0]  c_dest;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check stall, predict, clock, compare.
  task automatic apply_stimulus(input logic r, input logic [1:0] wb, input logic [1:0] mem,
                                input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] dest);
    exp_t e, o;
    logic exp_stall;
    logic [AW-1:0] w;
    rst = r; wb_in = wb; mem_in = mem; alu_res_in = alu; rt_in = rt; reg_dest_in = dest;
    #1;
    e = '{wb: 2'b00, rd: 32'h0, alu: 32'h0, dest: 5'h0, err: 1'b0};
    exp_stall = 1'b0;
    if (!r) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (mem != 2'b00 && alu[1:0] == 2'b00) begin
        exp_stall = 1'b1;
        c_wb = wb; c_mem = mem; c_alu = alu; c_rt = rt; c_dest = dest;
        m_busy = 1'b1;
        m_cnt  = ACCESS_LAT - 1;
      end else if (mem != 2'b00) begin
        e.alu = alu; e.dest = dest; e.err = 1'b1;
      end else begin
        e.wb = wb; e.alu = alu; e.dest = dest;
      end
    end else if (m_cnt != 0) begin
      exp_stall = 1'b1;
      m_cnt--;
    end else begin
      w = c_alu[AW+1:2];
      if (c_mem[0]) m_mem[w] = c_rt;
      e.wb = c_wb; e.alu = c_alu; e.dest = c_dest;
      e.rd = (c_mem == 2'b10) ? m_mem[w] : 32'h0;
      m_busy = 1'b0;
    end
    check_output("stall", {31'h0, stall}, {31'h0, exp_stall});
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    check_output("wb_out", {30'h0, wb_out}, {30'h0, o.wb});
    check_output("read_data_out", read_data_out, o.rd);
    check_output("alu_res_out", alu_res_out, o.alu);
    check_output("reg_dest_out", {27'h0, reg_dest_out}, {27'h0, o.dest});
    check_output("misalign_err", {31'h0, misalign_err}, {31'h0, o.err});
  endtask

  // Aligned memory op held for its whole ACCESS_LAT+1 cycles.
  task automatic do_access(input logic [1:0] wb, input logic [1:0] mem,
                           input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] dest);
    for (int i = 0; i <= ACCESS_LAT; i++) apply_stimulus(1'b1, wb, mem, alu, rt, dest);
  endtask

  initial begin
    logic [1:0]  rw, rm;
    logic [31:0] ra;
    apply_stimulus(1'b0, 2'b11, 2'b10, 32'h0000_0010, 32'h1, 5'd3);
    apply_stimulus(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);

    apply_stimulus(1'b1, 2'b10, 2'b00, 32'h0000_1234, 32'h0, 5'd5);

    do_access(2'b00, 2'b01, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
    do_access(2'b11, 2'b10, 32'h0000_0010, 32'h0, 5'd7);

    apply_stimulus(1'b1, 2'b11, 2'b10, 32'h0000_0013, 32'h0, 5'd9);
    apply_stimulus(1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
    apply_stimulus(1'b1, 2'b00, 2'b01, 32'h0000_0011, 32'h0000_0BAD, 5'd1);
    do_access(2'b11, 2'b10, 32'h0000_0010, 32'h0, 5'd8);

    do_access(2'b00, 2'b01, 32'h0000_0400, 32'hA5A5_A5A5, 5'd0);
    do_access(2'b11, 2'b10, 32'h0000_0000, 32'h0, 5'd2);

    do_access(2'b10, 2'b11, 32'h0000_0030, 32'h0000_0077, 5'd4);
    do_access(2'b11, 2'b10, 32'h0000_0030, 32'h0, 5'd4);

    do_access(2'b00, 2'b01, 32'h0000_0020, 32'h1111_1111, 5'd0);
    apply_stimulus(1'b1, 2'b00, 2'b01, 32'h0000_0020, 32'h0000_0055, 5'd0);
    apply_stimulus(1'b0, 2'b00, 2'b01, 32'h0000_0020, 32'h0000_0055, 5'd0);
    apply_stimulus(1'b1, 2'b01, 2'b00, 32'h0000_00AB, 32'h0, 5'd6);
    do_access(2'b11, 2'b10, 32'h0000_0020, 32'h0, 5'd10);

    for (int i = 0; i < 24; i++) begin
      rw = 2'($urandom_range(0, 3));
      rm = 2'($urandom_range(0, 3));
      ra = ($urandom() & 32'hFFFF_FC00) | (32'($urandom_range(0, 3)) << 4);
      if ($urandom_range(0, 3) == 0) ra[1:0] = 2'($urandom_range(1, 3));
      if (rm != 2'b00 && ra[1:0] == 2'b00)
        do_access(rw, rm, ra, $urandom(), 5'($urandom_range(0, 31)));
      else
        apply_stimulus(1'b1, rw, rm, ra, $urandom(), 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
